dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 13, byte-address width of data memory (8192 bytes).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 cpu_req  input  1  CPU MEM-stage access request, held high until cpu_ready.
REQ-005 cpu_we  input  1  CPU access type: 1 = store, 0 = load.
REQ-006 cpu_addr  input  ADDR_W  CPU base byte address.
REQ-007 cpu_wdata  input  64  CPU store data.
REQ-008 cpu_rdata  output  64  CPU load data.
REQ-009 cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-010 cpu_stall  output  1  pipeline freeze request to CPU.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/64  debug/loader port, same semantics as CPU port.
REQ-012 dbg_rdata  output  64; dbg_ready  output  1; same semantics as CPU port.
REQ-013 mem_en  output  1  byte-memory access strobe.
REQ-014 mem_we  output  1  byte write enable, valid with mem_en.
REQ-015 mem_addr  output  ADDR_W  byte address.
REQ-016 mem_wdata  output  8  byte write data.
REQ-017 mem_rdata  input  8  byte read data, valid exactly one cycle after a mem_en=1, mem_we=0 cycle.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 FSM states: IDLE, XFER, TAIL, DONE.
REQ-020 IDLE: at a rising edge with any request high, the FSM SHALL latch the winner's we/addr/wdata, set beat=0, and move to XFER.
REQ-021 Arbitration: one requester -> that requester; both -> the one not granted last (round-robin); last_grant resets to debug, so CPU wins the first tie.
REQ-022 XFER: mem_en=1, mem_we=latched we, mem_addr=(base+beat) mod 2^ADDR_W, mem_wdata=wdata[8*beat+7:8*beat]; beat increments each cycle; after beat 7 -> TAIL.
REQ-023 Byte order is little-endian: byte k of the 64-bit word at base+k.
REQ-024 Read capture: in the cycle after beat k, mem_rdata SHALL be stored into rbuf[8*k+7:8*k]; byte 7 is captured in TAIL.
REQ-025 TAIL: mem_en=0; next state DONE.
REQ-026 DONE: pulse the granted port's ready for exactly one cycle.
REQ-026a DONE, on a read: load the granted port's rdata register from rbuf at the DONE edge so rdata is valid while ready=1.
REQ-026b DONE, next state: IDLE; update last_grant.
REQ-027 Latency: request accepted at edge E -> ready high in the 10th cycle after E; IDLE->IDLE back-to-back gives one access every 11 cycles.
REQ-028 cpu_rdata/dbg_rdata SHALL hold their value until the next completed read on that port; a write SHALL NOT change them.
REQ-029 cpu_stall SHALL equal cpu_req AND NOT cpu_ready (combinational).
REQ-030 Unaligned base addresses are legal; address wrap past 2^ADDR_W-1 to 0 is legal.
REQ-031 A request dropped mid-transfer SHALL NOT abort it; the transfer completes and ready still pulses.
REQ-032 A losing requester SHALL stay pending; it is granted in the IDLE following DONE.
REQ-033 In IDLE, TAIL and DONE, mem_en=0 and mem_we=0.

Reset
REQ-034 On reset_n low, asynchronously: state=IDLE, beat=0, last_grant=debug, rbuf=0.
REQ-034a On reset_n low, asynchronously: cpu_rdata=0, dbg_rdata=0, cpu_ready=0, dbg_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-035 Reset mid-XFER SHALL abort immediately; bytes already written stay written, no ready pulse is issued, and operation resumes from IDLE after reset_n rises.

Verification
REQ-036 CPU store 0x1122334455667788 at 0x100 -> bytes 0x88..0x11 at 0x100..0x107; cpu_ready in cycle 10 after accept; cpu_stall high for 10 cycles.
REQ-037 CPU load from 0x100 after REQ-036 -> cpu_rdata=0x1122334455667788 with cpu_ready; dbg_rdata unchanged (0).
REQ-038 cpu_req and dbg_req rise together from reset -> CPU served first; debug accepted in the IDLE after CPU DONE; next simultaneous tie goes to CPU again.
REQ-039 Debug store at 0x1FFC (ADDR_W=13) -> bytes to 0x1FFC..0x1FFF then 0x0000..0x0003.
REQ-040 reset_n asserted during beat 3 of a store -> only bytes 0-2 written (beat 3 may or may not be, per edge), no ready pulse, busy=0 at once; a new request after release completes normally.
REQ-041 cpu_req dropped during XFER -> transfer still completes, with one cpu_ready pulse.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter that turns 64-bit word accesses into eight
// little-endian byte accesses on a byte-wide data memory.
module dmem_arbiter #(
    parameter int ADDR_W = 13
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic [63:0]       dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        beat;
    logic              last_grant;
    logic              grant;
    logic              xfer_we;
    logic [ADDR_W-1:0] base;
    logic [63:0]       xfer_wdata;
    logic [63:0]       rbuf;
    logic              pick_dbg;

    // grant/last_grant: 1 = debug port, 0 = CPU port; ties go to the port not served last
    always_comb begin
        pick_dbg = dbg_req && (!cpu_req || !last_grant);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            beat       <= 3'd0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            xfer_we    <= 1'b0;
            base       <= '0;
            xfer_wdata <= '0;
            rbuf       <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        grant      <= pick_dbg;
                        xfer_we    <= pick_dbg ? dbg_we : cpu_we;
                        base       <= pick_dbg ? dbg_addr : cpu_addr;
                        xfer_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
                        beat       <= 3'd0;
                        state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    // memory read data lags its strobe by one cycle, so capture the previous beat's byte
                    if (beat != 3'd0) begin
                        rbuf[{beat - 3'd1, 3'b000} +: 8] <= mem_rdata;
                    end
                    beat <= beat + 3'd1;
                    if (beat == 3'd7) begin
                        state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    rbuf[63:56] <= mem_rdata;
                    if (!xfer_we) begin
                        if (grant) begin
                            dbg_rdata <= {mem_rdata, rbuf[55:0]};
                        end else begin
                            cpu_rdata <= {mem_rdata, rbuf[55:0]};
                        end
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        mem_en    = (state == S_XFER);
        mem_we    = (state == S_XFER) && xfer_we;
        mem_addr  = (state == S_XFER) ? base + ADDR_W'(beat) : '0;
        mem_wdata = (state == S_XFER) ? xfer_wdata[{beat, 3'b000} +: 8] : 8'h00;
        cpu_ready = (state == S_DONE) && !grant;
        dbg_ready = (state == S_DONE) && grant;
        cpu_stall = cpu_req && !cpu_ready;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-wide memory model and
// hand-computed expected values.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [63:0] cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [12:0] dbg_addr;
    logic [63:0] dbg_wdata, dbg_rdata;
    logic        dbg_ready;
    logic        mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:8191];

    dmem_arbiter #(.ADDR_W(13)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // byte memory with one-cycle read latency
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clock);
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [63:0] read_word(input logic [12:0] addr);
        logic [63:0] w;
        logic [12:0] a;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            a = addr + 13'(k);
            w[8*k +: 8] = mem[a];
        end
        return w;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_ready(input bit use_dbg, output int cycles);
        cycles = -1;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clock);
            if (use_dbg ? dbg_ready : cpu_ready) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic run_access(input bit use_dbg, input bit we, input logic [12:0] addr,
                              input logic [63:0] wdata, output int latency,
                              output logic [63:0] rdata_seen, output int stall_cycles,
                              output logic en_tail, output logic [12:0] addr_b4);
        latency = -1;
        rdata_seen = '0;
        stall_cycles = 0;
        en_tail = 1'b1;
        addr_b4 = '0;
        if (use_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        #1;
        if (cpu_stall) stall_cycles++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 5) addr_b4 = mem_addr;
            if (n == 9) en_tail = mem_en;
            if (cpu_stall) stall_cycles++;
            if (use_dbg ? dbg_ready : cpu_ready) begin
                latency = n;
                rdata_seen = use_dbg ? dbg_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    int          lat, stalls, lat2, pulses;
    logic [63:0] rd;
    logic        en_t;
    logic [12:0] a4;

    initial begin
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(negedge clock);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_ready", {62'd0, cpu_ready, dbg_ready}, 64'd0);
        check_output("reset_mem_en", {62'd0, mem_en, mem_we}, 64'd0);
        check_output("reset_mem_addr", 64'(mem_addr), 64'd0);
        check_output("reset_rdata", cpu_rdata | dbg_rdata, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // CPU store, latency, stall window, byte placement
        run_access(0, 1, 13'h100, 64'h1122334455667788, lat, rd, stalls, en_t, a4);
        check_output("store_latency", 64'(lat), 64'd10);
        check_output("store_stall_cycles", 64'(stalls), 64'd10);
        check_output("store_tail_mem_en", 64'(en_t), 64'd0);
        check_output("store_beat4_addr", 64'(a4), 64'h104);
        @(negedge clock);
        check_output("ready_one_cycle", 64'(cpu_ready), 64'd0);
        check_output("idle_busy", 64'(busy), 64'd0);
        check_output("store_bytes", read_word(13'h100), 64'h1122334455667788);
        check_output("store_byte0", 64'(mem[13'h100]), 64'h88);

        // CPU load of the same word
        run_access(0, 0, 13'h100, 64'h0, lat, rd, stalls, en_t, a4);
        check_output("load_latency", 64'(lat), 64'd10);
        check_output("load_rdata", rd, 64'h1122334455667788);
        check_output("load_dbg_rdata_untouched", dbg_rdata, 64'd0);
        @(negedge clock);

        // a store must not disturb the held load data
        run_access(0, 1, 13'h108, 64'hDEADBEEFCAFEF00D, lat, rd, stalls, en_t, a4);
        check_output("hold_after_store", cpu_rdata, 64'h1122334455667788);
        @(negedge clock);
        run_access(1, 0, 13'h100, 64'h0, lat, rd, stalls, en_t, a4);
        check_output("dbg_load_latency", 64'(lat), 64'd10);
        check_output("dbg_load_rdata", rd, 64'h1122334455667788);
        check_output("dbg_load_dbg_stall", 64'(stalls), 64'd0);
        check_output("cpu_hold_after_dbg_load", cpu_rdata, 64'h1122334455667788);
        @(negedge clock);

        // debug store wrapping past the top of memory
        run_access(1, 1, 13'h1FFC, 64'h0807060504030201, lat, rd, stalls, en_t, a4);
        check_output("wrap_latency", 64'(lat), 64'd10);
        check_output("wrap_beat4_addr", 64'(a4), 64'h0000);
        check_output("wrap_top_bytes", {mem[13'h1FFF], mem[13'h1FFE], mem[13'h1FFD], mem[13'h1FFC]}, 64'h04030201);
        check_output("wrap_low_bytes", {mem[13'h0003], mem[13'h0002], mem[13'h0001], mem[13'h0000]}, 64'h08070605);
        @(negedge clock);

        // CPU load with request dropped mid-transfer
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFC;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clock);
            if (n == 3) cpu_req = 1'b0;
            if (cpu_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    rd = cpu_rdata;
                end
            end
        end
        check_output("drop_latency", 64'(lat), 64'd10);
        check_output("drop_pulses", 64'(pulses), 64'd1);
        check_output("drop_rdata", rd, 64'h0807060504030201);

        // reset during beat 3 of a store
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h400; cpu_wdata = 64'h8877665544332211;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_mem_en", 64'(mem_en), 64'd0);
        cpu_req = 1'b0;
        pulses = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            if (cpu_ready || dbg_ready) pulses++;
        end
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            if (cpu_ready || dbg_ready) pulses++;
        end
        check_output("abort_no_ready", 64'(pulses), 64'd0);
        check_output("abort_partial_bytes", read_word(13'h400), 64'h0000000000332211);
        check_output("abort_rdata_cleared", cpu_rdata, 64'd0);
        run_access(0, 1, 13'h400, 64'h8877665544332211, lat, rd, stalls, en_t, a4);
        check_output("post_abort_latency", 64'(lat), 64'd10);
        check_output("post_abort_bytes", read_word(13'h400), 64'h8877665544332211);

        // simultaneous requests from reset: CPU first, debug next, CPU again on next tie
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h200; cpu_wdata = 64'hA0A1A2A3A4A5A6A7;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 13'h300; dbg_wdata = 64'hB0B1B2B3B4B5B6B7;
        wait_ready(0, lat);
        check_output("tie1_cpu_latency", 64'(lat), 64'd10);
        check_output("tie1_dbg_not_ready", 64'(dbg_ready), 64'd0);
        cpu_req = 1'b0;
        wait_ready(1, lat2);
        check_output("tie1_dbg_latency", 64'(lat2), 64'd11);
        dbg_req = 1'b0;
        check_output("tie1_cpu_bytes", read_word(13'h200), 64'hA0A1A2A3A4A5A6A7);
        check_output("tie1_dbg_bytes", read_word(13'h300), 64'hB0B1B2B3B4B5B6B7);
        @(negedge clock);
        cpu_req = 1'b1; dbg_req = 1'b1;
        wait_ready(0, lat);
        check_output("tie2_cpu_latency", 64'(lat), 64'd10);
        check_output("tie2_dbg_not_ready", 64'(dbg_ready), 64'd0);
        cpu_req = 1'b0;
        wait_ready(1, lat2);
        check_output("tie2_dbg_latency", 64'(lat2), 64'd11);
        dbg_req = 1'b0;

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
